// File: rtl/sample_writer_pkg.sv
// Shared audio definitions for the sample writer: parameter defaults and
// FSM state encoding.
package sample_writer_pkg;

  localparam int SAMPLE_W_DEFAULT = 16;
  localparam int WAIT_MAX_DEFAULT = 15;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_SHIFT = 2'd3;

endpackage

// File: rtl/sample_shift_reg.sv
// Hold register and bit-index counter for one stereo frame.
// The hold register rotates left on every shift, so its MSB is always the
// bit on the wire. After 2*SAMPLE_W rotations it is back to the captured
// value, which lets a timed-out request replay the previous sample.
module sample_shift_reg
  import sample_writer_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
  localparam int IDX_W   = $clog2(2 * SAMPLE_W)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_i,
  input  logic                shift_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic                msb_d_o,
  output logic                right_d_o,
  output logic                last_o
);

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(2 * SAMPLE_W - 1);
  localparam logic [IDX_W-1:0] IDX_RIGHT = IDX_W'(SAMPLE_W);

  logic [SAMPLE_W-1:0] hold_q, hold_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  assign last_o = (idx_q == IDX_LAST);

  // Next hold value and bit index: load wins over shift; index wraps on the last bit
  always_comb begin
    hold_d = hold_q;
    idx_d  = idx_q;
    if (load_i) begin
      hold_d = sample_i;
      idx_d  = '0;
    end else if (shift_i) begin
      hold_d = {hold_q[SAMPLE_W-2:0], hold_q[SAMPLE_W-1]};
      idx_d  = last_o ? '0 : idx_q + IDX_W'(1);
    end else begin
      hold_d = hold_q;
      idx_d  = idx_q;
    end
  end

  // Look-ahead values so the parent can register sdata/lrclk in step with the state
  assign msb_d_o   = hold_d[SAMPLE_W-1];
  assign right_d_o = (idx_d >= IDX_RIGHT);

  // Hold register and index storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
      idx_q  <= '0;
    end else begin
      hold_q <= hold_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/sample_writer.sv
// Serial audio sample writer: requests a sample each frame, waits a bounded
// time for it, then shifts it out MSB first on the left and right channels.
module sample_writer
  import sample_writer_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
  parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_start,
  input  logic                bit_en,
  input  logic                sample_ready,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                clear_flags,
  output logic                generate_next,
  output logic                sdata,
  output logic                lrclk,
  output logic                busy,
  output logic                underrun,
  output logic                overrun
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
  logic gen_q, gen_d, sdata_q, sdata_d, lrclk_q, lrclk_d, busy_q, busy_d;
  logic under_q, under_d, over_q, over_d;
  logic load, shift, timeout, final_bit, over_set;
  logic msb_d, right_d, last_bit;

  assign shift    = (state_q == ST_SHIFT) && bit_en;
  assign wait_inc = wait_q + WAIT_W'(1);

  sample_shift_reg #(.SAMPLE_W(SAMPLE_W)) u_shift (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load),
    .shift_i   (shift),
    .sample_i  (sample),
    .msb_d_o   (msb_d),
    .right_d_o (right_d),
    .last_o    (last_bit)
  );

  // FSM next state, wait counter and capture/timeout decisions
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    load      = 1'b0;
    timeout   = 1'b0;
    final_bit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = frame_start ? ST_REQ : ST_IDLE;
      end
      ST_REQ: begin
        wait_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (sample_ready) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == WAIT_LIM) begin
            timeout = 1'b1;
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_SHIFT: begin
        if (bit_en && last_bit) begin
          // A frame_start landing on the final bit starts the next frame at once
          final_bit = 1'b1;
          state_d   = frame_start ? ST_REQ : ST_IDLE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky flags (a set event beats a same-cycle clear) and registered output values
  always_comb begin
    over_set = frame_start && (state_q != ST_IDLE) && !final_bit;
    under_d  = timeout  ? 1'b1 : (clear_flags ? 1'b0 : under_q);
    over_d   = over_set ? 1'b1 : (clear_flags ? 1'b0 : over_q);
    gen_d    = (state_d == ST_REQ);
    busy_d   = (state_d != ST_IDLE);
    sdata_d  = (state_d == ST_SHIFT) ? msb_d : 1'b0;
    lrclk_d  = (state_d == ST_SHIFT) ? right_d : 1'b0;
  end

  // State, counter, flags and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      gen_q   <= 1'b0;
      sdata_q <= 1'b0;
      lrclk_q <= 1'b0;
      busy_q  <= 1'b0;
      under_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      gen_q   <= gen_d;
      sdata_q <= sdata_d;
      lrclk_q <= lrclk_d;
      busy_q  <= busy_d;
      under_q <= under_d;
      over_q  <= over_d;
    end
  end

  assign generate_next = gen_q;
  assign sdata         = sdata_q;
  assign lrclk         = lrclk_q;
  assign busy          = busy_q;
  assign underrun      = under_q;
  assign overrun       = over_q;

endmodule

// File: doc/sample_writer.md
SAMPLE_WRITER -- requirements
Module: sample_writer

Interface
REQ-001 Parameter SAMPLE_W, default 16: width of one audio sample.
REQ-002 Parameter WAIT_MAX, default 15: maximum cycles spent waiting for sample_ready after a request.
REQ-003 clk  input  1: single clock; all state changes on its rising edge.
REQ-004 reset  input  1: asynchronous, active-low reset.
REQ-005 frame_start  input  1: one-cycle strobe marking the start of an output frame (sample rate).
REQ-006 bit_en  input  1: one-cycle strobe that advances the serial output by one bit.
REQ-007 sample_ready  input  1: sample-source strobe; sample is valid in that cycle.
REQ-008 sample  input  SAMPLE_W: two's-complement sample from the source.
REQ-009 clear_flags  input  1: synchronous clear of the sticky flags.
REQ-010 generate_next  output  1: one-cycle request for the next sample from the source.
REQ-011 sdata  output  1: serial data, MSB first.
REQ-012 lrclk  output  1: channel select; 0 = left half, 1 = right half.
REQ-013 busy  output  1: high in any state other than IDLE.
REQ-014 underrun  output  1: sticky; a request timed out.
REQ-015 overrun  output  1: sticky; frame_start arrived while not in IDLE.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, SHIFT.
REQ-017 IDLE: frame_start=1 -> REQ next cycle; otherwise stay in IDLE.
REQ-018 REQ: generate_next=1 for exactly this one cycle -> WAIT; the wait counter clears to 0.
REQ-019 generate_next is registered: it goes high the cycle after frame_start is accepted, and is never high outside REQ.
REQ-020 WAIT, sample_ready=1: capture sample into the hold register -> SHIFT; bit index = 0.
REQ-021 WAIT, no sample_ready: increment the wait counter; when it reaches WAIT_MAX, keep the previous hold value, set underrun -> SHIFT.
REQ-022 sample_ready outside WAIT is ignored; the hold register is unchanged.
REQ-023 SHIFT serialises 2*SAMPLE_W bits; bit index runs 0 .. 2*SAMPLE_W-1 and advances only on bit_en.
REQ-024 Output bits:
  - sdata = hold[SAMPLE_W-1 - (index mod SAMPLE_W)].
  - lrclk = 0 for index < SAMPLE_W, 1 otherwise.
  - The same sample is sent on both channels.
REQ-025 Entering SHIFT: sdata = hold MSB, lrclk = 0 in the first SHIFT cycle, before any bit_en.
REQ-026 bit_en at index 2*SAMPLE_W-1 -> IDLE. In IDLE, REQ and WAIT: sdata=0, lrclk=0.
REQ-027 frame_start while busy: the strobe is dropped, overrun is set, and the state is unaffected.
REQ-028 Exception: frame_start in the same cycle as the final bit_en is accepted -> REQ directly; overrun is not set.
REQ-029 bit_en outside SHIFT is ignored.
REQ-030 clear_flags clears underrun and overrun. A set event in the same cycle wins, so the flag stays 1.
REQ-031 Hold register width equals SAMPLE_W; no sign extension or arithmetic is applied.

Reset
REQ-032 reset=0 asynchronously forces:
  - state IDLE;
  - generate_next=0, sdata=0, lrclk=0, busy=0;
  - underrun=0, overrun=0;
  - hold=0, bit index=0, wait counter=0.
REQ-033 Reset asserted mid-SHIFT abandons the frame; after release the block waits in IDLE for a new frame_start.

Structure
REQ-034 A shared audio package holds the FSM state encoding, SAMPLE_W and WAIT_MAX defaults.
REQ-035 One sub-module, sample_shift_reg: load, shift-on-enable and bit-index counter; the FSM stays in sample_writer.

Verification
REQ-036 Basic frame:
  - Stimulus: frame_start; sample_ready 3 cycles after generate_next with sample=16'hA5C3; 32 bit_en strobes.
  - Response: sdata emits A5C3 MSB-first twice; lrclk is 0 for the first 16 bits and 1 for the last 16; busy drops after the 32nd bit_en.
REQ-037 Timeout:
  - Stimulus: previous hold 16'h1234; no sample_ready.
  - Response: underrun=1 after 15 WAIT cycles; the frame serialises 16'h1234 on both channels.
REQ-038 Overrun:
  - Stimulus: frame_start at bit index 10.
  - Response: overrun=1; the current frame completes unchanged; no generate_next.
REQ-039 Back-to-back: frame_start coincident with the final bit_en -> generate_next on the next cycle; overrun stays 0.
REQ-040 Reset mid-frame: reset=0 at bit index 20 -> all outputs 0 immediately; after release, no activity until frame_start.
REQ-041 Flag race: clear_flags in the same cycle as a timeout -> underrun=1; a later clear_flags alone -> underrun=0.
